// File: rtl/soc_bus_pkg.sv
// Shared constants and types for the data-side bus slave.
// MMIO offsets, CTRL bit positions, reset values and region select.
package soc_bus_pkg;

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_COUNT = 8'h08;
  localparam logic [7:0] OFF_CMP   = 8'h0C;
  localparam logic [7:0] OFF_CTRL  = 8'h10;
  localparam logic [7:0] OFF_SEG   = 8'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_ACLR  = 1;
  localparam int CTRL_FLAG  = 2;
  localparam int CTRL_IRQEN = 3;

  localparam logic [31:0] RST_COUNT = 32'h0000_0000;
  localparam logic [31:0] RST_CMP   = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_SEG   = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_MMIO,
    SEL_NONE
  } sel_e;

  function automatic logic [31:0] merge_be(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_data_bus_timer.sv
// 32-bit timer: COUNT/CMP/CTRL with compare match flag and IRQ.
// Core writes to COUNT beat auto-clear, which beats increment.
module soc_timer
  import soc_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic [3:0]  count_we,
  input  logic [3:0]  cmp_we,
  input  logic        ctrl_we,
  output logic [31:0] count_o,
  output logic [31:0] cmp_o,
  output logic [31:0] ctrl_o,
  output logic        irq_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        aclr_q, aclr_d;
  logic        flag_q, flag_d;
  logic        irqen_q, irqen_d;
  logic        irq_q, irq_d;
  logic        match;
  logic        flag_clr;

  always_comb begin
    match    = en_q && (count_q == cmp_q);
    count_d  = count_q;
    cmp_d    = merge_be(cmp_q, wdata, cmp_we);
    en_d     = en_q;
    aclr_d   = aclr_q;
    irqen_d  = irqen_q;
    flag_clr = 1'b0;
    if (|count_we) begin
      count_d = merge_be(count_q, wdata, count_we);
    end else if (match && aclr_q) begin
      count_d = '0;
    end else if (en_q) begin
      count_d = count_q + 32'd1;
    end
    if (ctrl_we) begin
      en_d     = wdata[CTRL_EN];
      aclr_d   = wdata[CTRL_ACLR];
      irqen_d  = wdata[CTRL_IRQEN];
      flag_clr = wdata[CTRL_FLAG];
    end
    // a new match wins over a simultaneous W1C
    flag_d = match | (flag_q & ~flag_clr);
    irq_d  = flag_q & irqen_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_COUNT;
      cmp_q   <= RST_CMP;
      en_q    <= 1'b0;
      aclr_q  <= 1'b0;
      flag_q  <= 1'b0;
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      aclr_q  <= aclr_d;
      flag_q  <= flag_d;
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = {28'd0, irqen_q, flag_q, aclr_q, en_q};
  assign irq_o   = irq_q;

endmodule

// File: rtl/soc_data_bus.sv
// Data-side bus slave: address decode, data RAM, LED/SW/SEG MMIO.
// Read data is combinational so the single-cycle core sees it at once.
module soc_data_bus
  import soc_bus_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
  parameter int          SW_WIDTH  = 16,
  parameter int          LED_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           we,
  output logic [31:0]          rdata,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [31:0]          seg_out,
  output logic                 timer_irq,
  output logic                 bus_err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) * 33'd4;

  sel_e                 sel;
  logic [7:0]           off;
  logic [AW-1:0]        idx;
  logic [3:0]           mmio_we;
  logic [3:0]           ram_we;
  logic [31:0]          mem [RAM_WORDS];
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          seg_q, seg_d;
  logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
  logic                 bus_err_q;
  logic [31:0]          count, cmp, ctrl;

  always_comb begin
    sel = SEL_NONE;
    if ({1'b0, addr} < RAM_LIMIT) begin
      sel = SEL_RAM;
    end else if (addr[31:8] == MMIO_BASE[31:8]) begin
      sel = SEL_MMIO;
    end
  end

  assign off     = addr[7:0] & 8'hFC;
  assign idx     = addr[AW+1:2];
  assign mmio_we = (sel == SEL_MMIO) ? we : 4'b0000;
  assign ram_we  = (sel == SEL_RAM && !rst) ? we : 4'b0000;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    led_d = led_q;
    seg_d = seg_q;
    if (off == OFF_LED) begin
      for (int b = 0; b < LED_WIDTH; b++) begin
        if (mmio_we[b/8]) begin
          led_d[b] = wdata[b];
        end
      end
    end
    if (off == OFF_SEG) begin
      seg_d = merge_be(seg_q, wdata, mmio_we);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      seg_q     <= RST_SEG;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      bus_err_q <= (sel == SEL_NONE);
    end
  end

  soc_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .wdata    (wdata),
    .count_we ((off == OFF_COUNT) ? mmio_we : 4'b0000),
    .cmp_we   ((off == OFF_CMP) ? mmio_we : 4'b0000),
    .ctrl_we  ((off == OFF_CTRL) && mmio_we[0]),
    .count_o  (count),
    .cmp_o    (cmp),
    .ctrl_o   (ctrl),
    .irq_o    (timer_irq)
  );

  always_comb begin
    rdata = '0;
    unique case (sel)
      SEL_RAM: rdata = mem[idx];
      SEL_MMIO: begin
        case (off)
          OFF_LED:   rdata = 32'(led_q);
          OFF_SW:    rdata = 32'(sw_sync_q);
          OFF_COUNT: rdata = count;
          OFF_CMP:   rdata = cmp;
          OFF_CTRL:  rdata = ctrl;
          OFF_SEG:   rdata = seg_q;
          default:   rdata = '0;
        endcase
      end
      default: rdata = '0;
    endcase
  end

  assign led_out = led_q;
  assign seg_out = seg_q;
  assign bus_err = bus_err_q;

endmodule
